// File: rtl/apb_bridge_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_arbiter_if
// Brief    : Requester-side and bridge-side (PM) signal bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_bridge_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      REQ;
    logic [NREQ*32-1:0]   REQ_ADDR;
    logic [NREQ*32-1:0]   REQ_WDATA;
    logic [NREQ-1:0]      REQ_WRITE;
    logic [NREQ-1:0]      DONE;
    logic [31:0]          RDATA;
    logic                 ERR;
    logic                 TOUT;
    logic [31:0]          PADDR_PM;
    logic                 PWRITE_PM;
    logic                 PENABLE_PM;
    logic [31:0]          PWDATA_PM;
    logic [31:0]          PRDATA_PM;
    logic                 PREADY_PM;
    logic                 PSLVERR_PM;

    modport master (
        input  REQ, REQ_ADDR, REQ_WDATA, REQ_WRITE,
        input  PRDATA_PM, PREADY_PM, PSLVERR_PM,
        output DONE, RDATA, ERR, TOUT,
        output PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM
    );

    modport slave (
        output REQ, REQ_ADDR, REQ_WDATA, REQ_WRITE,
        output PRDATA_PM, PREADY_PM, PSLVERR_PM,
        input  DONE, RDATA, ERR, TOUT,
        input  PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM
    );
endinterface
`default_nettype wire

// File: rtl/apb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_arbiter
// Brief    : Round-robin sharing of the PM port of the APB clock-crossing
//            bridge, with per-access watchdog and late-response drain.
// Revision : 1.0 - initial release
// ============================================================================
module apb_bridge_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  wire logic             PCLK_PM,
    input  wire logic             PRESETN_PM,
    apb_bridge_arbiter_if.master  bus_io
);
    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_ACCESS   = 3'd2,
        S_COMPLETE = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gnt_q;
    logic [15:0]     wdog_q;
    logic [31:0]     paddr_q;
    logic [31:0]     pwdata_q;
    logic            pwrite_q;
    logic            penable_q;
    logic [NREQ-1:0] done_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            tout_q;

    logic            gnt_vld_d;
    logic [PW-1:0]   gnt_idx_d;
    logic [31:0]     gnt_addr_d;
    logic [31:0]     gnt_wdata_d;
    logic            gnt_write_d;
    logic [PW-1:0]   ptr_d;
    int              scan_idx;

    // Scan downward in priority so the requester nearest to ptr wins last.
    always_comb begin
        gnt_vld_d   = 1'b0;
        gnt_idx_d   = '0;
        gnt_addr_d  = '0;
        gnt_wdata_d = '0;
        gnt_write_d = 1'b0;
        scan_idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (bus_io.REQ[scan_idx]) begin
                gnt_vld_d   = 1'b1;
                gnt_idx_d   = PW'(scan_idx);
                gnt_addr_d  = bus_io.REQ_ADDR[32*scan_idx +: 32];
                gnt_wdata_d = bus_io.REQ_WDATA[32*scan_idx +: 32];
                gnt_write_d = bus_io.REQ_WRITE[scan_idx];
            end
        end
    end

    assign ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            wdog_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q    <= gnt_idx_d;
                        paddr_q  <= gnt_addr_d;
                        pwdata_q <= gnt_wdata_d;
                        pwrite_q <= gnt_write_d;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    wdog_q    <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus_io.PREADY_PM) begin
                        rdata_q   <= bus_io.PRDATA_PM;
                        err_q     <= bus_io.PSLVERR_PM;
                        done_q    <= NREQ'(1) << gnt_q;
                        penable_q <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        pwrite_q  <= 1'b0;
                        ptr_q     <= ptr_d;
                        state_q   <= S_COMPLETE;
                    end else if (WD_EN && (wdog_q == WD_LAST)) begin
                        // Abandon the access; the bridge may still answer later.
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        tout_q    <= 1'b1;
                        done_q    <= NREQ'(1) << gnt_q;
                        penable_q <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        pwrite_q  <= 1'b0;
                        ptr_q     <= ptr_d;
                        state_q   <= S_DRAIN;
                    end else if (wdog_q != 16'hFFFF) begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                S_COMPLETE: begin
                    done_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    // The stale response is swallowed here, never reported.
                    done_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    tout_q  <= 1'b0;
                    if (bus_io.PREADY_PM) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_io.DONE       = done_q;
    assign bus_io.RDATA      = rdata_q;
    assign bus_io.ERR        = err_q;
    assign bus_io.TOUT       = tout_q;
    assign bus_io.PADDR_PM   = paddr_q;
    assign bus_io.PWDATA_PM  = pwdata_q;
    assign bus_io.PWRITE_PM  = pwrite_q;
    assign bus_io.PENABLE_PM = penable_q;

endmodule
`default_nettype wire
